// File: rtl/fetch_queue_pkg.sv
// fetch_queue shared types: widths, opcodes, FSM encodings, queue entry.
// Imported by the fetch interface, the instruction FIFO and the fetch top.
package fetch_queue_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_WAIT = 2'd1,
    FQ_HOLD = 2'd2,
    FQ_DROP = 2'd3
  } fq_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } fq_entry_t;

  function automatic logic is_ctrl(
    input logic [INST_WIDTH-1:0] inst
  );
    return (inst[6:0] == OP_JAL)  ||
           (inst[6:0] == OP_JALR) ||
           (inst[6:0] == OP_BRANCH);
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        en
  );
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch bus: memory request/response plus decode head handshake.
// master = fetch stage, slave = memory controller / decoder side.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic                  if2mem_req;
  logic [ADDR_WIDTH-1:0] if2mem_addr;
  logic                  mem2if_valid;
  logic [INST_WIDTH-1:0] mem2if_inst;
  logic                  if2dec;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic [INST_WIDTH-1:0] inst_out;
  logic                  dec_ready;

  modport master (
    output if2mem_req, if2mem_addr,
    output if2dec, pc_out, inst_out,
    input  mem2if_valid, mem2if_inst,
    input  dec_ready
  );

  modport slave (
    input  if2mem_req, if2mem_addr,
    input  if2dec, pc_out, inst_out,
    output mem2if_valid, mem2if_inst,
    output dec_ready
  );

endinterface

// File: rtl/fetch_queue_inst_fifo.sv
// inst_fifo: power-of-two {pc, inst} queue with clear and enable.
// Head reads as zero while empty.
module inst_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst_in,
  input  logic      en,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  fq_entry_t din,
  output fq_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(do_push)
                       - CW'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && do_push && !clear)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: single-outstanding word fetch into an instruction queue.
// Optional FETCH_QUEUE_STATS_EN adds fetched/hold/dropped counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                    IQ_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  fetch_queue_if.master         bus,
  input  logic                  dec_redirect,
  input  logic [ADDR_WIDTH-1:0] dec_redirect_pc,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]           stat_fetched,
  output logic [31:0]           stat_hold_cycles,
  output logic [31:0]           stat_dropped
`endif
);

  fq_state_t             state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic                  req, req_n;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  mem_v;
  logic                  outstanding;
  fq_entry_t             head;

  assign mem_v       = bus.mem2if_valid;
  assign outstanding = (state == FQ_WAIT) ||
                       (state == FQ_DROP);
  assign pop         = !empty && bus.dec_ready
                       && rdy_in;

  inst_fifo #(.DEPTH(IQ_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_in(rst_in),
    .en    (rdy_in),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .din   ('{pc: pc, inst: bus.mem2if_inst}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = addr;
    req_n   = req;
    push    = 1'b0;
    if (flush || dec_redirect) begin
      pc_n = flush ? flush_pc : dec_redirect_pc;
      // A response landing this cycle retires the request itself.
      if (outstanding && !mem_v) begin
        state_n = FQ_DROP;
      end else begin
        state_n = FQ_IDLE;
        req_n   = 1'b0;
      end
    end else begin
      case (state)
        FQ_IDLE: begin
          if (!full) begin
            req_n   = 1'b1;
            addr_n  = pc;
            state_n = FQ_WAIT;
          end
        end
        FQ_WAIT: begin
          if (mem_v) begin
            push  = 1'b1;
            req_n = 1'b0;
            if (is_ctrl(bus.mem2if_inst)) begin
              state_n = FQ_HOLD;
            end else begin
              pc_n    = pc + ADDR_WIDTH'(4);
              state_n = FQ_IDLE;
            end
          end
        end
        FQ_HOLD: ;
        FQ_DROP: begin
          if (mem_v) begin
            req_n   = 1'b0;
            state_n = FQ_IDLE;
          end
        end
        default: state_n = FQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state <= FQ_IDLE;
      pc    <= RESET_PC;
      addr  <= '0;
      req   <= 1'b0;
    end else if (rdy_in) begin
      state <= state_n;
      pc    <= pc_n;
      addr  <= addr_n;
      req   <= req_n;
    end
  end

  assign bus.if2mem_req  = req;
  assign bus.if2mem_addr = addr;
  assign bus.if2dec      = !empty;
  assign bus.pc_out      = head.pc;
  assign bus.inst_out    = head.inst;

`ifdef FETCH_QUEUE_STATS_EN
  logic drop_ev;
  assign drop_ev = outstanding && mem_v &&
                   (flush || dec_redirect ||
                    state == FQ_DROP);

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      stat_fetched     <= '0;
      stat_hold_cycles <= '0;
      stat_dropped     <= '0;
    end else if (rdy_in) begin
      stat_fetched <= sat_inc(stat_fetched, push);
      stat_hold_cycles <= sat_inc(stat_hold_cycles,
                                  state == FQ_HOLD);
      stat_dropped <= sat_inc(stat_dropped, drop_ev);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: opcode table plus fetch/hold/flush/redirect sequences.
// Popped heads are checked against an expected-entry scoreboard queue.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        dec_redirect;
  logic [31:0] dec_redirect_pc;
  logic        flush;
  logic [31:0] flush_pc;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_hold_cycles;
  logic [31:0] stat_dropped;
`endif

  fetch_queue_if ifc();

  fetch_queue #(
    .IQ_DEPTH(8),
    .RESET_PC(32'h0)
  ) dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .bus            (ifc),
    .dec_redirect   (dec_redirect),
    .dec_redirect_pc(dec_redirect_pc),
    .flush          (flush),
    .flush_pc       (flush_pc)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stat_fetched    (stat_fetched),
    .stat_hold_cycles(stat_hold_cycles),
    .stat_dropped    (stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] opc;
    bit         hold;
  } vec_t;

  vec_t        vecs[8];
  int          checks   = 0;
  int          failures = 0;
  int          pops     = 0;
  int          mem_lat  = 2;
  int          lat      = 0;
  logic        req_prev = 1'b0;
  logic [31:0] special_addr = '1;
  logic [31:0] special_inst = '0;
  logic [31:0] req_log[$];
  fq_entry_t   exp_q[$];

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == special_addr) return special_inst;
    return {a[24:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] logq(input int i);
    if (req_log.size() > i) return req_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input int n);
    int t = 0;
    while (req_log.size() < n && t < 100) begin
      tick(1);
      t++;
    end
    chk("wait_req_count", req_log.size() >= n, 1);
  endtask

  task automatic wait_pops(input int n);
    int t = 0;
    while (pops < n && t < 120) begin
      tick(1);
      t++;
    end
    chk("wait_pops_count", pops >= n, 1);
  endtask

  task automatic do_reset();
    rst_in          = 1'b1;
    rdy_in          = 1'b1;
    ifc.dec_ready   = 1'b0;
    dec_redirect    = 1'b0;
    flush           = 1'b0;
    dec_redirect_pc = '0;
    flush_pc        = '0;
    mem_lat         = 2;
    special_addr    = '1;
    tick(2);
    req_log.delete();
    exp_q.delete();
    pops = 0;
    chk("rst_req", ifc.if2mem_req, 0);
    chk("rst_addr", ifc.if2mem_addr, 0);
    chk("rst_if2dec", ifc.if2dec, 0);
    chk("rst_pc_out", ifc.pc_out, 0);
    chk("rst_inst_out", ifc.inst_out, 0);
`ifdef FETCH_QUEUE_STATS_EN
    chk("rst_stat_fetched", stat_fetched, 0);
    chk("rst_stat_dropped", stat_dropped, 0);
`endif
    rst_in = 1'b0;
  endtask

  // Memory model, request logger and pop scoreboard.
  initial begin
    fq_entry_t e;
    ifc.mem2if_valid = 1'b0;
    ifc.mem2if_inst  = '0;
    forever begin
      @(negedge clk);
      if (rst_in) begin
        ifc.mem2if_valid = 1'b0;
        lat      = 0;
        req_prev = 1'b0;
      end else begin
        if (ifc.if2mem_req && !req_prev)
          req_log.push_back(ifc.if2mem_addr);
        req_prev = ifc.if2mem_req;
        if (ifc.if2dec && ifc.dec_ready && rdy_in) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected got=%h exp=none",
                     ifc.pc_out);
          end else begin
            e = exp_q.pop_front();
            chk("pop_pc", ifc.pc_out, e.pc);
            chk("pop_inst", ifc.inst_out, e.inst);
          end
          pops++;
        end
        if (!rdy_in) begin
          ifc.mem2if_valid = 1'b0;
        end else if (ifc.mem2if_valid) begin
          ifc.mem2if_valid = 1'b0;
        end else if (ifc.if2mem_req) begin
          lat++;
          if (lat >= mem_lat) begin
            ifc.mem2if_valid = 1'b1;
            ifc.mem2if_inst  = rom(ifc.if2mem_addr);
            lat = 0;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    vecs[0] = '{opc: OP_JAL,       hold: 1'b1};
    vecs[1] = '{opc: OP_JALR,      hold: 1'b1};
    vecs[2] = '{opc: OP_BRANCH,    hold: 1'b1};
    vecs[3] = '{opc: 7'b0010011,   hold: 1'b0};
    vecs[4] = '{opc: 7'b0110111,   hold: 1'b0};
    vecs[5] = '{opc: 7'b0000011,   hold: 1'b0};
    vecs[6] = '{opc: 7'b1101011,   hold: 1'b0};
    vecs[7] = '{opc: 7'b1100110,   hold: 1'b0};

    // Opcode table: word at PC 0 either parks the fetcher or not.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      special_addr = 32'h0;
      special_inst = {25'h0155AA3, vecs[i].opc};
      tick(30);
      chk("tbl_hold", req_log.size() == 1, vecs[i].hold);
      chk("tbl_head_pc", ifc.pc_out, 0);
      chk("tbl_head_inst", ifc.inst_out, special_inst);
    end

    // Sequential fetch with decode always ready.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      a = 32'(k * 4);
      exp_q.push_back('{pc: a, inst: rom(a)});
    end
    ifc.dec_ready = 1'b1;
    wait_pops(4);
    ifc.dec_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      chk("seq_req_addr", logq(k), 32'(k * 4));

    // Queue full, rdy_in freeze, then a single pop restarts fetch.
    do_reset();
    tick(60);
    chk("full_nreq", req_log.size(), 8);
    chk("full_req_low", ifc.if2mem_req, 0);
    chk("full_if2dec", ifc.if2dec, 1);
    for (int k = 0; k < 8; k++)
      chk("full_req_addr", logq(k), 32'(k * 4));
    rdy_in        = 1'b0;
    ifc.dec_ready = 1'b1;
    tick(5);
    chk("frz_pc_out", ifc.pc_out, 0);
    chk("frz_inst_out", ifc.inst_out, rom(0));
    chk("frz_if2dec", ifc.if2dec, 1);
    chk("frz_req", ifc.if2mem_req, 0);
    chk("frz_pops", pops, 0);
    rdy_in        = 1'b1;
    ifc.dec_ready = 1'b0;
    tick(1);
    chk("frz_nreq", req_log.size(), 8);
    exp_q.push_back('{pc: 32'h0, inst: rom(0)});
    ifc.dec_ready = 1'b1;
    tick(1);
    ifc.dec_ready = 1'b0;
    chk("one_pop", pops, 1);
    chk("one_pop_head", ifc.pc_out, 32'h4);
    wait_req(9);
    chk("refill_addr", logq(8), 32'h20);

    // Branch at 0x8 parks fetch until decode redirects to 0x40.
    do_reset();
    special_addr = 32'h8;
    special_inst = {25'h0000123, OP_BRANCH};
    tick(40);
    chk("br_nreq", req_log.size(), 3);
    chk("br_req_low", ifc.if2mem_req, 0);
`ifdef FETCH_QUEUE_STATS_EN
    chk("br_hold_nz", stat_hold_cycles != 0, 1);
`endif
    dec_redirect    = 1'b1;
    dec_redirect_pc = 32'h40;
    tick(1);
    dec_redirect = 1'b0;
    wait_req(4);
    chk("redir_addr", logq(3), 32'h40);
    exp_q.push_back('{pc: 32'h0, inst: rom(32'h0)});
    exp_q.push_back('{pc: 32'h4, inst: rom(32'h4)});
    exp_q.push_back('{pc: 32'h8, inst: special_inst});
    exp_q.push_back('{pc: 32'h40, inst: rom(32'h40)});
    exp_q.push_back('{pc: 32'h44, inst: rom(32'h44)});
    ifc.dec_ready = 1'b1;
    wait_pops(5);
    ifc.dec_ready = 1'b0;

    // Flush while the 0xC request is outstanding.
    do_reset();
    mem_lat = 4;
    wait_req(4);
    chk("fl_pre_req", ifc.if2mem_req, 1);
    chk("fl_pre_addr", ifc.if2mem_addr, 32'hC);
    flush    = 1'b1;
    flush_pc = 32'h100;
    tick(1);
    flush = 1'b0;
    chk("fl_if2dec", ifc.if2dec, 0);
    chk("fl_pc_out", ifc.pc_out, 0);
    chk("fl_req_held", ifc.if2mem_req, 1);
    wait_req(5);
    chk("fl_next_addr", logq(4), 32'h100);
`ifdef FETCH_QUEUE_STATS_EN
    chk("fl_stat_dropped", stat_dropped, 1);
    chk("fl_stat_fetched", stat_fetched, 3);
`endif
    exp_q.push_back('{pc: 32'h100, inst: rom(32'h100)});
    ifc.dec_ready = 1'b1;
    wait_pops(1);
    ifc.dec_ready = 1'b0;

    // Flush beats redirect in the same cycle.
    do_reset();
    special_addr = 32'h8;
    special_inst = {25'h0000456, OP_BRANCH};
    tick(40);
    chk("fr_nreq", req_log.size(), 3);
    flush           = 1'b1;
    flush_pc        = 32'h200;
    dec_redirect    = 1'b1;
    dec_redirect_pc = 32'h80;
    tick(1);
    flush        = 1'b0;
    dec_redirect = 1'b0;
    chk("fr_if2dec", ifc.if2dec, 0);
    wait_req(4);
    chk("fr_next_addr", logq(3), 32'h200);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
